// File: rtl/dispatch_arb.sv
// dispatch_arb: in-order dispatch queue between the identify stage and
// the branch / condition-register units, with halt-on-unknown and flush.
module dispatch_arb #(
    parameter int DEPTH = 4,
    parameter int AFULL = DEPTH - 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [0:31]            i_instr,
    input  logic                   i_branch_identified,
    input  logic                   i_condreg_identified,
    input  logic                   i_unknown_instr,
    output logic                   o_arb_full_mask,
    output logic                   o_br_valid,
    input  logic                   i_br_ready,
    output logic [0:31]            o_br_instr,
    output logic                   o_cr_valid,
    input  logic                   i_cr_ready,
    output logic [0:31]            o_cr_instr,
    input  logic                   i_flush,
    input  logic                   i_resume,
    output logic                   o_illegal,
    output logic                   o_halted,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AFULL);

    localparam logic [1:0] CLS_BR  = 2'b01;
    localparam logic [1:0] CLS_CR  = 2'b10;
    localparam logic [1:0] CLS_UNK = 2'b11;

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] HALT  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [0:31]   q_instr [DEPTH];
    logic [1:0]    q_cls   [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [1:0]    push_cls;
    logic [1:0]    head_cls;
    logic          head_run;
    logic          push;
    logic          pop;

    // Class of the incoming word; a word with no flag is treated as unknown.
    always_comb begin
        push_cls = CLS_UNK;
        if (i_branch_identified) begin
            push_cls = CLS_BR;
        end else if (i_condreg_identified) begin
            push_cls = CLS_CR;
        end else if (i_unknown_instr) begin
            push_cls = CLS_UNK;
        end
    end

    // Head presentation, halt detection and push/pop qualification.
    always_comb begin
        head_cls        = q_cls[rd_ptr];
        head_run        = (state == RUN) && (count != '0);
        o_br_valid      = head_run && (head_cls == CLS_BR);
        o_cr_valid      = head_run && (head_cls == CLS_CR);
        o_illegal       = head_run && (head_cls == CLS_UNK) && !i_flush;
        o_halted        = (state == HALT);
        o_br_instr      = q_instr[rd_ptr];
        o_cr_instr      = q_instr[rd_ptr];
        o_count         = count;
        o_arb_full_mask = (count >= AF_CNT) || (state == FLUSH);
        pop  = (o_br_valid && i_br_ready)
            || (o_cr_valid && i_cr_ready)
            || (o_halted && i_resume);
        push = i_en && !i_flush && (state != FLUSH)
            && ((count != FULL_CNT) || pop);
    end

    // Next state; flush overrides everything else.
    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = FLUSH;
        end else begin
            case (state)
                RUN:     if (o_illegal) state_nxt = HALT;
                HALT:    if (i_resume)  state_nxt = RUN;
                FLUSH:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Pointers, occupancy and state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            state  <= RUN;
        end else begin
            state <= state_nxt;
            if (i_flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Entry storage; contents are only meaningful below the count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            q_instr[wr_ptr] <= i_instr;
            q_cls[wr_ptr]   <= push_cls;
        end
    end
endmodule

// File: doc/dispatch_arb.md
DISPATCH_ARB -- requirements
Module: dispatch_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter AFULL, default DEPTH-1, meaning occupancy at which o_arb_full_mask asserts.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_en  input  1  push qualifier from the identify stage.
REQ-006 SHALL have port i_instr  input  [0:31]  identified instruction word (suffix).
REQ-007 SHALL have port i_branch_identified / i_condreg_identified / i_unknown_instr  input  1 each  class flags, one-hot when i_en=1.
REQ-008 SHALL have port o_arb_full_mask  output  1  back-pressure to the identify stage.
REQ-009 SHALL have ports o_br_valid  output  1, i_br_ready  input  1, o_br_instr  output  [0:31]  branch-unit channel.
REQ-010 SHALL have ports o_cr_valid  output  1, i_cr_ready  input  1, o_cr_instr  output  [0:31]  condition-register-unit channel.
REQ-011 SHALL have ports i_flush  input  1, i_resume  input  1  pipeline flush and resume after halt.
REQ-012 SHALL have ports o_illegal  output  1, o_halted  output  1, o_count  output  [$clog2(DEPTH):0]  status.

Function
REQ-013 SHALL store each entry as {instr, 2-bit class: BR=01, CR=10, UNK=11} in an in-order circular queue.
REQ-014 SHALL push when i_en=1, occupancy<DEPTH, no flush; push with queue full SHALL be dropped, queue unchanged.
REQ-015 SHALL push an entry with no class flag set as UNK.
REQ-016 SHALL drive o_arb_full_mask = (o_count >= AFULL), combinational from registered count.
REQ-017 SHALL present only the head entry; o_br_valid=1 iff state RUN, queue non-empty, head class BR; o_cr_valid likewise for CR; never both.
REQ-018 SHALL pop the head in the cycle valid&ready is high on its channel; o_*_instr = head instr whenever valid, stable until accepted.
REQ-019 SHALL allow push and pop in the same cycle, occupancy unchanged, including when full (pop frees the slot for the push).
REQ-020 SHALL wrap read/write pointers modulo DEPTH with no bubble.
REQ-021 SHALL implement states RUN, HALT, FLUSH.
REQ-022 RUN->HALT when head class is UNK: o_illegal pulses high exactly one cycle, entry not dispatched.
REQ-023 HALT: no valid asserted, pushes still accepted; o_halted=1.
REQ-024 HALT->RUN on i_resume=1: UNK head popped that cycle; i_resume in RUN or FLUSH SHALL be ignored.
REQ-025 Any state->FLUSH on i_flush=1: queue emptied at next edge, concurrent push discarded, o_illegal not raised.
REQ-026 FLUSH->RUN unconditionally the following cycle; no valid and no push during FLUSH; o_arb_full_mask=1 in FLUSH.
REQ-027 i_flush SHALL take priority over i_resume, push and pop in the same cycle.
REQ-028 Dispatch latency: entry pushed at edge N SHALL be presentable at cycle N+1 when it is head (no same-cycle bypass).

Reset
REQ-029 i_rst=0 SHALL asynchronously clear pointers, o_count=0, state=RUN, o_illegal=0, o_halted=0, o_br_valid=0, o_cr_valid=0, o_arb_full_mask=0.
REQ-030 Reset mid-dispatch SHALL discard all entries; nothing re-presented after release.
REQ-031 First push SHALL be accepted at the first rising edge with i_rst=1.

Verification
REQ-032 Push branch 0x48032BFB, i_br_ready=1 -> o_br_valid=1 one cycle after push, o_br_instr=0x48032BFB, o_count 1->0.
REQ-033 Push 4 CR entries, i_cr_ready=0 -> o_count=4, o_arb_full_mask=1 from count 3; 5th push dropped; then ready=1 drains in order, 1/cycle.
REQ-034 Push BR, UNK, CR, all ready=1 -> BR dispatched, o_illegal one-cycle pulse, o_halted=1, CR held; i_resume=1 -> CR dispatched next cycle.
REQ-035 Queue with 3 entries, i_flush=1 with simultaneous i_en=1 -> o_count=0 next cycle, FLUSH one cycle, then RUN, no valid seen.
REQ-036 Queue full, push and pop same cycle for 8 cycles -> o_count stays 4, pointers wrap twice, order preserved.
REQ-037 Assert i_rst=0 between edges with 2 entries -> outputs clear immediately, o_count=0, no dispatch after release.
